// File: rtl/adder_arbiter.sv
// Shares one 32-bit carry-lookahead adder among NREQ valid/ready requesters.
// Define ADDER_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).

module Adder32 (
  input  logic [31:0] in1_i,
  input  logic [31:0] in2_i,
  input  logic        cin_i,
  output logic [32:0] sum_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  // 4-bit lookahead groups, group carries chained across the eight groups
  always_comb begin
    g  = in1_i & in2_i;
    p  = in1_i ^ in2_i;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+2 +: 2] & g[4*k+1])
            | (&p[4*k+1 +: 3] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin_i;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k +: 2] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (&p[4*k+1 +: 2] & g[4*k])
               | (&p[4*k +: 3] & gc[k]);
    end
  end

  assign sum_o = {gc[8], p ^ c};

endmodule

module adder_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [32*NREQ-1:0]   req_in1,
  input  logic [32*NREQ-1:0]   req_in2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [32:0]          rsp_sum
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     in1_q, in1_d;
  logic [31:0]     in2_q, in2_d;
  logic            cin_q, cin_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [32:0]     rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  cand;
  logic            any_valid;
  logic [32:0]     add_sum;

  logic [31:0]     in1_arr [NREQ];
  logic [31:0]     in2_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign in1_arr[gi] = req_in1[32*gi +: 32];
    assign in2_arr[gi] = req_in2[32*gi +: 32];
  end

  // Adder only ever sees the latched operands
  Adder32 u_adder (
    .in1_i (in1_q),
    .in2_i (in2_q),
    .cin_i (cin_q),
    .sum_o (add_sum)
  );

`ifdef ADDER_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Search upward from the pointer, wrapping at NREQ
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr_q) + i) % NREQ);
      if (!any_valid && req_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'(i);
      if (!any_valid && req_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    in1_d       = in1_q;
    in2_d       = in2_q;
    cin_d       = cin_q;
    id_d        = id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
`ifdef ADDER_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready[grant] = 1'b1;
          in1_d            = in1_arr[grant];
          in2_d            = in2_arr[grant];
          cin_d            = req_cin[grant];
          id_d             = grant;
          state_d          = CALC;
`ifdef ADDER_ARB_RR_EN
          ptr_d            = IDW'((32'(grant) + 32'd1) % NREQ);
`endif
        end
      end
      CALC: begin
        rsp_sum_d   = add_sum;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in1_q       <= '0;
      in2_q       <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
`ifdef ADDER_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef ADDER_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: expected sums queued on acceptance, compared on response.

module tb_adder_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_cin;
  logic [32*NREQ-1:0]  req_in1;
  logic [32*NREQ-1:0]  req_in2;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [32:0]         rsp_sum;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int          exp_id_q[$];
  logic [32:0] exp_sum_q[$];
  int          acc_id_q[$];
  int          acc_cyc_q[$];

  adder_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cin   (req_cin),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic c);
    return 33'(a) + 33'(b) + 33'(c);
  endfunction

  // Acceptance pushes the model result; response handshake pops and compares
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_id_q.delete();
      exp_sum_q.delete();
    end else begin
      if (req_ready != '0) begin
        check("ready_onehot", 64'($onehot(req_ready & req_valid)), 64'd1);
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i] && req_valid[i]) begin
            exp_id_q.push_back(i);
            exp_sum_q.push_back(model_add(req_in1[32*i +: 32], req_in2[32*i +: 32], req_cin[i]));
            acc_id_q.push_back(i);
            acc_cyc_q.push_back(cyc);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_sum_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          check("rsp_id", 64'(rsp_id), 64'(exp_id_q.pop_front()));
          check("rsp_sum", 64'(rsp_sum), 64'(exp_sum_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_ready(input int id, input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = req_ready[id];
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      ok = (exp_sum_q.size() == 0) && !rsp_valid && (req_valid == '0);
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input bit corrupt);
    @(posedge clk); #1;
    req_valid[id]          = 1'b1;
    req_in1[32*id +: 32]   = a;
    req_in2[32*id +: 32]   = b;
    req_cin[id]            = c;
    wait_ready(id, "accept_timeout");
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (corrupt) begin
      req_in1[32*id +: 32] = ~a;
      req_cin[id]          = ~c;
    end
    @(negedge clk);
    check("lat_calc_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("lat_resp_rsp_valid", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int n0;
    int exp_order [5];
`ifdef ADDER_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif

    rst_n     = 1'b0;
    req_valid = '0;
    req_cin   = '0;
    req_in1   = '0;
    req_in2   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    rst_n = 1'b1;

    send(2, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0);
    check("basic_sum", 64'(rsp_sum), 64'h0_0000_0009);
    check("basic_id", 64'(rsp_id), 64'd2);
    send(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("carry_sum", 64'(rsp_sum), 64'h1_0000_0000);
    send(3, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    check("carry2_sum", 64'(rsp_sum), 64'h1_0000_0001);
    send(1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    check("isolation_sum", 64'(rsp_sum), 64'h0_0000_0030);
    for (int k = 0; k < 6; k++) begin
      send(int'($urandom_range(0, NREQ-1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Backpressure with requesters 0 and 1 pending
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    req_valid[1:0]  = 2'b11;
    req_in1[31:0]   = 32'h0000_0100;
    req_in2[31:0]   = 32'h0000_0001;
    req_cin[0]      = 1'b0;
    req_in1[63:32]  = 32'h0000_0200;
    req_in2[63:32]  = 32'h0000_0002;
    req_cin[1]      = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_sum", 64'(rsp_sum), 64'h0_2345_6789);
      check("bp_rsp_id", 64'(rsp_id), 64'd1);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("bp_idle_grant", 64'(req_ready), 64'b0001);
    check("bp_idle_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_ready(1, "bp_second_timeout");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain("bp_drain_timeout");

    // Contention from a fresh pointer
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = acc_id_q.size();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_in1[32*i +: 32] = $urandom;
      req_in2[32*i +: 32] = $urandom;
      req_cin[i]          = 1'($urandom_range(0, 1));
    end
    req_valid = '1;
    for (int t = 0; t < 100 && acc_id_q.size() < n0 + 5; t++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    check("cont_timeout", 64'(acc_id_q.size() >= n0 + 5), 64'd1);
    if (acc_id_q.size() >= n0 + 5) begin
      for (int i = 0; i < 5; i++) check("cont_grant", 64'(acc_id_q[n0+i]), 64'(exp_order[i]));
      for (int i = 1; i < 5; i++)
        check("cont_spacing", 64'(acc_cyc_q[n0+i] - acc_cyc_q[n0+i-1]), 64'd3);
    end
    drain("cont_drain_timeout");

    // Asynchronous reset while in CALC
    @(posedge clk); #1;
    req_valid[3]    = 1'b1;
    req_in1[127:96] = 32'h0000_0ABC;
    req_in2[127:96] = 32'h0000_0001;
    req_cin[3]      = 1'b0;
    wait_ready(3, "rstcalc_accept_timeout");
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstcalc_req_ready", 64'(req_ready), 64'd0);
    check("rstcalc_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstcalc_rsp_id", 64'(rsp_id), 64'd0);
    check("rstcalc_rsp_sum", 64'(rsp_sum), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    send(2, 32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0);
    check("post_rst_sum", 64'(rsp_sum), 64'h0_0000_000F);
    check("post_rst_id", 64'(rsp_id), 64'd2);
    drain("final_drain_timeout");
    check("sb_empty", 64'(exp_sum_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one 32-bit carry-lookahead adder (`Adder32`, instantiated internally) among `NREQ` requesters. Each requester offers `{cin, in1, in2}` on a valid/ready channel. The arbiter grants one request at a time, registers the operands, computes the 33-bit sum and returns it with the requester index on a single valid/ready response channel. It sits between the integer-unit clients and the shared adder datapath.

## Interface
- `NREQ`, 4: number of requesters, legal 2..8.
- `IDW`, `$clog2(NREQ)`: derived, width of the requester index.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  bit i: requester i offers an operation.
- `req_ready`  out  NREQ  bit i: requester i accepted this cycle (one-hot or zero).
- `req_cin`  in  NREQ  bit i: carry-in of requester i.
- `req_in1`  in  32*NREQ  slice [32i+31:32i]: operand 1 of requester i.
- `req_in2`  in  32*NREQ  slice [32i+31:32i]: operand 2 of requester i.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  IDW  index of the requester owning the result.
- `rsp_sum`  out  33  `{carry_out, sum[31:0]}` = `in1 + in2 + cin`.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant g is chosen combinationally from `req_valid` (policy below).
  - `req_ready[g]` = 1 if any `req_valid`; all other bits are 0.
  - On handshake, latch `req_cin[g]`, `req_in1[g]`, `req_in2[g]` and g into internal registers, then go to CALC.
  - With no valid request: stay in IDLE, `req_ready` = 0.
- **CALC**
  - The adder sees only the latched operands.
  - At the clock edge, register the adder output into `rsp_sum` and g into `rsp_id`, then go to RESP.
  - `req_ready` = 0.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_sum` and `rsp_id` are held stable until `rsp_ready` = 1. Then go to IDLE.
  - `req_ready` = 0 throughout. No acceptance happens in the same cycle as response completion.
- **Request changes:** a requester may drop `req_valid` before being granted, and nothing is recorded. After acceptance, changes on request inputs do not affect the in-flight result.
- **Arithmetic:** unsigned 33-bit result. Bit 32 is the carry out. No overflow flag.
  - Example: `FFFFFFFF + 00000001 + 0` = `1_00000000`.
- **Reset mid-operation:** asynchronous. FSM goes to IDLE, the transaction in flight is discarded, and no response is issued.

## Timing
- **Reset values:**
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0.
  - Round-robin pointer = 0.
- **Latency:** request accepted at edge N gives `rsp_valid` = 1 in cycle N+2 (after edge N+1).
- **Throughput:** at most one operation per 3 cycles, with `rsp_ready` tied high.
- **Output sourcing:**
  - `req_ready` is combinational from state, `req_valid` and the pointer.
  - `rsp_*` are registered.
- **Simultaneous `req_valid`:** exactly one grant per acceptance. Non-granted requesters keep waiting with `req_ready` = 0.

## Configuration
- `ADDER_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at pointer p and ascends modulo NREQ.
  - On each acceptance, p <= (g+1) mod NREQ.
- `ADDER_ARB_RR_EN` undefined: fixed priority.
  - The lowest valid index wins.
  - The pointer logic is absent.
  - A permanently asserting requester 0 may starve the others.

## Test plan
- **Single request, basic add:** requester 2 sends `in1=00000005`, `in2=00000003`, `cin=1`.
  - Accepted in cycle 0; `rsp_valid` in cycle 2 with `rsp_sum=0_00000009`, `rsp_id=2`.
- **Carry out:** `in1=FFFFFFFF`, `in2=00000001`, `cin=0`.
  - `rsp_sum=1_00000000`.
  - Also `80000000 + 80000000 + 1` gives `1_00000001`.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles in RESP.
  - `rsp_valid`, `rsp_sum`, `rsp_id` stay stable.
  - All `req_ready` stay 0 while requesters 0 and 1 are pending.
  - Releasing `rsp_ready` returns the FSM to IDLE next cycle.
- **Contention:** all 4 requesters hold `req_valid` continuously with `rsp_ready=1`.
  - With `ADDER_ARB_RR_EN`: grant order 0,1,2,3,0.
  - Without it: grant order 0,0,0.
  - Acceptances are exactly 3 cycles apart.
- **Reset in CALC:** assert `rst_n=0` asynchronously mid-cycle.
  - All outputs go to reset values immediately.
  - After release, no stale `rsp_valid`; the next request completes normally.
- **Operand isolation:** change `req_in1` of the granted requester in the cycle after acceptance.
  - The result reflects the originally latched values.
